// File: rtl/serial_word_collect.sv
// rtl/serial_word_collect.sv - collects an LSB-first serial frame into a parallel word with valid/ready output

module serial_word_collect #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic             frame_start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             neg,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic             load_first;
    logic             shift_in;
    logic             complete;
    logic [WIDTH-1:0] new_word;

    // The completed word is the bits collected so far with the final bit on top.
    assign new_word = {d_in, shreg[WIDTH-2:0]};

    // Next-state decode: start, extend, resync or finish a frame.
    always_comb begin
        state_next = state;
        load_first = 1'b0;
        shift_in   = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid) begin
                    load_first = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (d_valid) begin
                    if (frame_start) begin
                        load_first = 1'b1;
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        shift_in = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks COLLECT exactly.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == COLLECT);
        end
    end

    // Shift register and bit counter; bits above cnt are always zero so OR-in is safe.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load_first) begin
            shreg <= {{(WIDTH-1){1'b0}}, d_in};
            cnt   <= CW'(1);
        end else if (shift_in) begin
            shreg <= shreg | ({{(WIDTH-1){1'b0}}, d_in} << cnt);
            cnt   <= cnt + CW'(1);
        end else if (complete) begin
            shreg <= '0;
            cnt   <= '0;
        end
    end

    // Output word, valid/ready handshake and sticky overrun for words that had nowhere to go.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            neg        <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            if (!word_valid || out_ready) begin
                word_out   <= new_word;
                neg        <= d_in;
                word_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (word_valid && out_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_collect.sv
// tb/tb_serial_word_collect.sv - scoreboard bench for serial_word_collect

module tb_serial_word_collect;

    logic       t_clk = 1'b0;
    logic       r = 1'b1;
    logic       d_in = 1'b0;
    logic       d_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] word_out;
    logic       word_valid;
    logic       neg;
    logic       busy;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    logic [8:0] exp_q[$];

    serial_word_collect #(.WIDTH(8)) dut (
        .t_clk(t_clk),
        .r(r),
        .d_in(d_in),
        .d_valid(d_valid),
        .frame_start(frame_start),
        .out_ready(out_ready),
        .word_out(word_out),
        .word_valid(word_valid),
        .neg(neg),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 t_clk = ~t_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        d_in = b;
        d_valid = 1'b1;
        frame_start = fs;
        @(posedge t_clk);
        #1;
        d_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge t_clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], 1'b0);
            if (gap > 0 && i < 7) begin
                idle(gap);
                check("busy_in_gap", busy, 1);
            end
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge t_clk) begin
        if (!r && word_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", word_out, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("sb_word", word_out, e[7:0]);
                check("sb_neg", neg, e[8]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        check("rst_word_out", word_out, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_neg", neg, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        r = 1'b0;
        idle(1);

        // 1: basic frame 1,1,0,1,1,1,1,1 -> 0xFB with out_ready low
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        send_bit(1, 0); send_bit(1, 0); send_bit(1, 0);
        check("t1_valid_before_last", word_valid, 0);
        check("t1_busy_before_last", busy, 1);
        send_bit(1, 0);
        check("t1_valid", word_valid, 1);
        check("t1_word", word_out, 8'hFB);
        check("t1_neg", neg, 1);
        check("t1_busy", busy, 0);
        check("t1_overrun", overrun, 0);
        idle(2);
        check("t1_hold_word", word_out, 8'hFB);
        exp_q.push_back({1'b1, 8'hFB});
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("t1_valid_after_xfer", word_valid, 0);

        // 2: gapped frame 0x02
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h02});
        send_word(8'h02, 2);
        check("t2_word", word_out, 8'h02);
        check("t2_neg", neg, 0);
        idle(2);

        // 3: three stale bits then a resync frame 0x01
        exp_q.push_back({1'b0, 8'h01});
        send_bit(1, 0); send_bit(1, 0); send_bit(1, 0);
        send_bit(1, 1);
        for (int i = 0; i < 7; i++) send_bit(0, 0);
        check("t3_word", word_out, 8'h01);
        idle(2);

        // 4: back-to-back frames with out_ready high
        exp_q.push_back({1'b1, 8'hFB});
        exp_q.push_back({1'b0, 8'h05});
        send_word(8'hFB, 0);
        check("t4_valid_first", word_valid, 1);
        send_word(8'h05, 0);
        check("t4_valid_second", word_valid, 1);
        check("t4_word_second", word_out, 8'h05);
        idle(1);
        check("t4_valid_drop", word_valid, 0);
        check("t4_overrun", overrun, 0);

        // 5: overrun - second word dropped while first is unaccepted
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 8'hFB});
        send_word(8'hFB, 0);
        send_word(8'h05, 0);
        check("t5_word_held", word_out, 8'hFB);
        check("t5_valid", word_valid, 1);
        check("t5_overrun", overrun, 1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("t5_valid_after_xfer", word_valid, 0);
        check("t5_overrun_sticky", overrun, 1);

        // 6: asynchronous reset mid-frame, then frame 0x80
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        #2;
        r = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_word", word_out, 0);
        check("t6_rst_valid", word_valid, 0);
        check("t6_rst_neg", neg, 0);
        @(posedge t_clk);
        #1;
        r = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 8'h80});
        send_word(8'h80, 0);
        check("t6_word", word_out, 8'h80);
        check("t6_neg", neg, 1);
        idle(2);
        out_ready = 1'b0;

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
